// File: rtl/tt_um_r0_core.sv
// tt_um_r0_core: tiny 4-register accumulator core.
// One instruction executes per clk edge while ena is high; uo_out shows a
// selected register or the flag pair, chosen by the VIEW instruction.
module tt_um_r0_core (
  input  logic       clk,
  input  logic       rst_n,    // active-high synchronous reset despite the name
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_INC = 4'hB;
  localparam logic [3:0] OP_DEC = 4'hC;
  localparam logic [3:0] OP_ADC = 4'hD;
  localparam logic [3:0] OP_VIEW = 4'hE;
  localparam logic [3:0] OP_CLR = 4'hF;

  logic [7:0] regs [4];
  logic       flag_c;
  logic       flag_z;
  logic [2:0] sel;

  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [8:0] result;
  logic       wr_en;
  logic       c_next;
  logic       z_upd;

  assign opcode = ui_in[7:4];
  assign rd     = ui_in[3:2];
  assign rs     = ui_in[1:0];
  assign op_a   = regs[rd];
  assign op_b   = regs[rs];

  // The pads are never driven; all uio pins stay inputs.
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Decode and compute the result of the current instruction from pre-edge state;
  // result[8] carries the carry/borrow out for the arithmetic ops.
  always_comb begin
    result = 9'd0;
    wr_en  = 1'b0;
    c_next = flag_c;
    z_upd  = 1'b0;
    case (opcode)
      OP_LDI: begin result = {1'b0, uio_in}; wr_en = 1'b1; end
      OP_MOV: begin result = {1'b0, op_b};   wr_en = 1'b1; end
      OP_ADD: begin
        result = {1'b0, op_a} + {1'b0, op_b};
        wr_en = 1'b1; c_next = result[8]; z_upd = 1'b1;
      end
      OP_SUB: begin
        // 9-bit wrap sets bit 8 exactly when op_a < op_b
        result = {1'b0, op_a} - {1'b0, op_b};
        wr_en = 1'b1; c_next = result[8]; z_upd = 1'b1;
      end
      OP_AND: begin result = {1'b0, op_a & op_b}; wr_en = 1'b1; z_upd = 1'b1; end
      OP_OR:  begin result = {1'b0, op_a | op_b}; wr_en = 1'b1; z_upd = 1'b1; end
      OP_XOR: begin result = {1'b0, op_a ^ op_b}; wr_en = 1'b1; z_upd = 1'b1; end
      OP_NOT: begin result = {1'b0, ~op_b};       wr_en = 1'b1; z_upd = 1'b1; end
      OP_SHL: begin
        result = {1'b0, op_b[6:0], 1'b0};
        wr_en = 1'b1; c_next = op_b[7]; z_upd = 1'b1;
      end
      OP_SHR: begin
        result = {2'b00, op_b[7:1]};
        wr_en = 1'b1; c_next = op_b[0]; z_upd = 1'b1;
      end
      OP_INC: begin
        result = {1'b0, op_a} + 9'd1;
        wr_en = 1'b1; c_next = result[8]; z_upd = 1'b1;
      end
      OP_DEC: begin
        result = {1'b0, op_a} - 9'd1;
        wr_en = 1'b1; c_next = result[8]; z_upd = 1'b1;
      end
      OP_ADC: begin
        result = {1'b0, op_a} + {1'b0, op_b} + {8'd0, flag_c};
        wr_en = 1'b1; c_next = result[8]; z_upd = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural state update: reset wins, then ena gates every instruction.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      sel    <= 3'd0;
    end else if (ena) begin
      if (opcode == OP_CLR) begin
        for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        flag_c <= 1'b0;
        flag_z <= 1'b0;
      end else if (opcode == OP_VIEW) begin
        sel <= ui_in[2:0];
      end else begin
        if (wr_en) regs[rd] <= result[7:0];
        flag_c <= c_next;
        if (z_upd) flag_z <= (result[7:0] == 8'h00);
      end
    end
  end

  // Output view mux; selects 5-7 read as zero.
  always_comb begin
    uo_out = 8'h00;
    case (sel)
      3'd0: uo_out = regs[0];
      3'd1: uo_out = regs[1];
      3'd2: uo_out = regs[2];
      3'd3: uo_out = regs[3];
      3'd4: uo_out = {6'b0, flag_z, flag_c};
      default: uo_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tt_um_r0_core.sv
// Scoreboard bench for tt_um_r0_core: the stimulus process pushes the uo_out
// value expected after each edge; the monitor pops and compares after the edge.
module tb_tt_um_r0_core;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_entry_t;

  sb_entry_t sb[$];
  int total = 0;
  int bad   = 0;

  tt_um_r0_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs at the falling edge and queue the expected view.
  task automatic step(input logic r, input logic e, input logic [7:0] ins,
                      input logic [7:0] imm, input logic [7:0] exp, input string nm);
    sb_entry_t ent;
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = ins;
    uio_in = imm;
    ent.exp  = exp;
    ent.name = nm;
    sb.push_back(ent);
  endtask

  // Monitor: after each rising edge, retire one expectation if any is pending.
  initial begin
    sb_entry_t ent;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        ent = sb.pop_front();
        total++;
        if (uo_out !== ent.exp) begin
          bad++;
          $display("FAIL %s: uo_out=%02h want=%02h", ent.name, uo_out, ent.exp);
        end
        total++;
        if ({uio_out, uio_oe} !== 16'h0000) begin
          bad++;
          $display("FAIL %s_uio: uio_out=%02h uio_oe=%02h want=00/00", ent.name, uio_out, uio_oe);
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    //     rst   ena   instr  imm    expect name
    step(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, "reset");
    step(1'b0, 1'b1, 8'h10, 8'h5A, 8'h5A, "ldi_r0_5a");

    step(1'b0, 1'b1, 8'h10, 8'hF0, 8'hF0, "ldi_r0_f0");
    step(1'b0, 1'b1, 8'h14, 8'h20, 8'hF0, "ldi_r1_20");
    step(1'b0, 1'b1, 8'h31, 8'h99, 8'h10, "add_r0_r1");
    step(1'b0, 1'b1, 8'hE4, 8'h00, 8'h01, "view4_add");

    step(1'b0, 1'b1, 8'h18, 8'h03, 8'h01, "ldi_r2_flags_kept");
    step(1'b0, 1'b1, 8'h4A, 8'h3C, 8'h02, "sub_r2_r2_flags");
    step(1'b0, 1'b1, 8'hE2, 8'h00, 8'h00, "view2_zero");
    step(1'b0, 1'b1, 8'hC8, 8'h00, 8'hFF, "dec_r2_wrap");
    step(1'b0, 1'b1, 8'hE4, 8'h00, 8'h01, "view4_dec");

    step(1'b0, 1'b1, 8'h1C, 8'h81, 8'h01, "ldi_r3_81");
    step(1'b0, 1'b1, 8'h9F, 8'h00, 8'h01, "shl_r3_flags");
    step(1'b0, 1'b1, 8'hE3, 8'h00, 8'h02, "view3_shl");
    step(1'b0, 1'b1, 8'hDF, 8'h00, 8'h05, "adc_r3_r3");
    step(1'b0, 1'b1, 8'hE4, 8'h00, 8'h00, "view4_adc");

    step(1'b0, 1'b1, 8'hB8, 8'h00, 8'h03, "inc_r2_wrap");
    step(1'b0, 1'b1, 8'h87, 8'h00, 8'h01, "not_r1_flags");
    step(1'b0, 1'b1, 8'hE1, 8'h00, 8'hFA, "view1_not");
    step(1'b0, 1'b1, 8'hA5, 8'h00, 8'h7D, "shr_r1");
    step(1'b0, 1'b1, 8'h75, 8'h00, 8'h00, "xor_r1_r1");
    step(1'b0, 1'b1, 8'hE4, 8'h00, 8'h02, "view4_xor");
    step(1'b0, 1'b1, 8'hE0, 8'h00, 8'h10, "view0");
    step(1'b0, 1'b1, 8'h63, 8'h00, 8'h15, "or_r0_r3");
    step(1'b0, 1'b1, 8'h51, 8'h00, 8'h00, "and_r0_r1");
    step(1'b0, 1'b1, 8'h23, 8'hEE, 8'h05, "mov_r0_r3");
    step(1'b0, 1'b1, 8'h14, 8'h06, 8'h05, "ldi_r1_06");
    step(1'b0, 1'b1, 8'h41, 8'h00, 8'hFF, "sub_borrow");
    step(1'b0, 1'b1, 8'hE5, 8'h00, 8'h00, "view5");
    step(1'b0, 1'b1, 8'hE4, 8'h00, 8'h01, "view4_borrow");
    step(1'b0, 1'b1, 8'h00, 8'hA5, 8'h01, "nop");

    step(1'b0, 1'b1, 8'hE0, 8'h00, 8'hFF, "view0_r0");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 8'h10, 8'hAA, 8'hFF, "ena0_hold");
    step(1'b0, 1'b0, 8'hE4, 8'h00, 8'hFF, "ena0_view_hold");
    step(1'b0, 1'b1, 8'h10, 8'hAA, 8'hAA, "ena1_ldi");

    step(1'b1, 1'b1, 8'h10, 8'h77, 8'h00, "reset_over_ldi");
    step(1'b0, 1'b1, 8'hE4, 8'h00, 8'h00, "flags_after_reset");
    step(1'b0, 1'b1, 8'hE0, 8'h00, 8'h00, "r0_after_reset");

    step(1'b0, 1'b1, 8'h10, 8'hFF, 8'hFF, "ldi_r0_ff");
    step(1'b0, 1'b1, 8'hB0, 8'h00, 8'h00, "inc_r0_wrap");
    step(1'b0, 1'b1, 8'hE4, 8'h00, 8'h03, "view4_inc");
    step(1'b0, 1'b1, 8'hF0, 8'h00, 8'h00, "clr_flags");
    step(1'b0, 1'b1, 8'hE0, 8'h00, 8'h00, "clr_r0");
    step(1'b0, 1'b1, 8'h10, 8'hFF, 8'hFF, "ldi_r0_ff_2");
    step(1'b0, 1'b1, 8'hD0, 8'h00, 8'hFE, "adc_no_carry_in");
    step(1'b0, 1'b1, 8'h14, 8'h02, 8'hFE, "ldi_r1_02");
    step(1'b0, 1'b1, 8'h31, 8'h00, 8'h00, "add_to_zero");
    step(1'b0, 1'b1, 8'hE4, 8'h00, 8'h03, "view4_add_zero");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_r0_core.md
TT_UM_R0_CORE -- requirements
Module: tt_um_r0

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have rst_n  input  1  synchronous reset, asserted when rst_n=1 (active-high despite the name).
REQ-003 SHALL have ena  input  1  execute enable; 0 = hold all state.
REQ-004 SHALL have ui_in  input  8  instruction: [7:4] opcode, [3:2] rd, [1:0] rs.
REQ-005 SHALL have uio_in  input  8  immediate data for LDI.
REQ-006 SHALL have uo_out  output  8  view of selected register or flags.
REQ-007 SHALL have uio_out  output  8  constant 0x00.
REQ-008 SHALL have uio_oe  output  8  constant 0x00 (all uio pins are inputs).

Function
REQ-009 SHALL hold state R0-R3 (8-bit each), flags C and Z, and a 3-bit view select SEL.
REQ-010 SHALL execute one instruction per rising clk edge when ena=1 and reset is deasserted; results appear on uo_out after that same edge (single-cycle latency, no pipeline).
REQ-011 SHALL drive uo_out combinationally from state: SEL 0-3 gives Rn; SEL 4 gives {6'b0, Z, C}; SEL 5-7 gives 0x00.
REQ-012 SHALL decode opcodes (all arithmetic modulo 256):
- 0 NOP: no change.
- 1 LDI: rd=uio_in; flags unchanged.
- 2 MOV: rd=rs; flags unchanged.
- 3 ADD: rd=rd+rs; C=carry out.
- 4 SUB: rd=rd-rs; C=borrow (1 when rd<rs).
- 5 AND, 6 OR, 7 XOR: rd=rd op rs; C unchanged.
- 8 NOT: rd=~rs; C unchanged.
- 9 SHL: rd=rs<<1; C=rs[7].
- A SHR: rd=rs>>1 (logical); C=rs[0].
- B INC: rd=rd+1; C=1 only on 0xFF->0x00.
- C DEC: rd=rd-1; C=1 only on 0x00->0xFF.
- D ADC: rd=rd+rs+C; C=carry out.
- E VIEW: SEL=ui_in[2:0]; registers and flags unchanged.
- F CLR: R0-R3, C, Z all cleared; SEL unchanged.
REQ-013 SHALL set Z=1 iff the 8-bit result is 0x00 for opcodes 3-D; Z unchanged for 0, 1, 2, E.
REQ-014 SHALL use pre-edge values for all operands when rd=rs (e.g. ADD R1,R1 doubles R1).
REQ-015 SHALL read uio_in only for LDI; ignore ena-independent uio_in changes otherwise.
REQ-016 SHALL hold every register, flag and SEL unchanged while ena=0, regardless of ui_in.

Reset
REQ-017 SHALL, on any rising edge with rst_n=1, clear R0-R3, C, Z to 0 and SEL to 0, so uo_out=0x00 after the edge.
REQ-018 SHALL give reset priority over ena and any instruction on the same edge.
REQ-019 SHALL keep uio_out=0x00 and uio_oe=0x00 at all times, including during reset.

Verification
REQ-020 SHALL pass: reset, then LDI R0 with uio_in=0x5A -> uo_out=0x5A after one edge.
REQ-021 SHALL pass: R0=0xF0, R1=0x20, ADD R0,R1, VIEW 4 -> R0=0x10, uo_out=0x01 (C=1, Z=0).
REQ-022 SHALL pass: R2=0x03, SUB R2,R2 then VIEW 4 -> uo_out=0x02 (Z=1, C=0); DEC R2 -> R2=0xFF, C=1.
REQ-023 SHALL pass: R3=0x81, SHL R3,R3, VIEW 3 -> uo_out=0x02, C=1; then ADC R3,R3 -> R3=0x05.
REQ-024 SHALL pass: ena=0 with LDI R0 and uio_in=0xAA for 3 cycles -> uo_out unchanged; ena=1 -> 0xAA next edge.
REQ-025 SHALL pass: rst_n=1 mid-sequence with ena=1 and LDI R0 0x77 present -> all state 0, uo_out=0x00, LDI not performed.
